// File: rtl/ro_meas_pkg.sv
// ro_meas_pkg: shared state type, default widths and saturation helper for the ring-oscillator measurement controller
`timescale 1ns/1ps
package ro_meas_pkg;
    typedef enum logic [1:0] {IDLE, WARMUP, MEASURE, DONE} state_e;
    localparam int WIN_W_DEF = 16;
    localparam int CNT_W_DEF = 16;
    function automatic logic [31:0] max_cnt(input int w);
        return (w >= 32) ? '1 : (32'd1 << w) - 32'd1;
    endfunction
endpackage

// File: rtl/ro_meas_ctrl_if.sv
// ro_meas_ctrl_if: CSR/oscillator/result bundle of the measurement controller
// Optional alarm signals appear when RO_MEAS_ALARM_EN is defined.
`timescale 1ns/1ps
interface ro_meas_ctrl_if import ro_meas_pkg::*; #(
    parameter int WIN_W = WIN_W_DEF,
    parameter int CNT_W = CNT_W_DEF
);
    logic start;
    logic [WIN_W-1:0] win_len;
    logic ro_en;
    logic ro_clk;
    logic busy;
    logic cnt_valid;
    logic cnt_ready;
    logic [CNT_W-1:0] cnt_data;
    logic cnt_ovf;
`ifdef RO_MEAS_ALARM_EN
    logic [CNT_W-1:0] lim_lo;
    logic [CNT_W-1:0] lim_hi;
    logic alarm;
    modport slave (input start, win_len, ro_clk, cnt_ready, lim_lo, lim_hi,
                   output ro_en, busy, cnt_valid, cnt_data, cnt_ovf, alarm);
    modport master (output start, win_len, ro_clk, cnt_ready, lim_lo, lim_hi,
                    input ro_en, busy, cnt_valid, cnt_data, cnt_ovf, alarm);
`else
    modport slave (input start, win_len, ro_clk, cnt_ready,
                   output ro_en, busy, cnt_valid, cnt_data, cnt_ovf);
    modport master (output start, win_len, ro_clk, cnt_ready,
                    input ro_en, busy, cnt_valid, cnt_data, cnt_ovf);
`endif
endinterface

// File: rtl/ro_sync_edge.sv
// ro_sync_edge: multi-stage synchronizer for the asynchronous oscillator plus a one-cycle rising-edge pulse
`timescale 1ns/1ps
module ro_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic pulse_o
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic prev_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end
    assign pulse_o = sync_q[SYNC_STAGES-1] & ~prev_q;
endmodule

// File: rtl/ro_meas_ctrl.sv
// ro_meas_ctrl: enables a ring oscillator, warms it up, counts its edges over a window and hands the count out.
// Define RO_MEAS_ALARM_EN to add the sticky out-of-range alarm with lim_lo/lim_hi.
`timescale 1ns/1ps
module ro_meas_ctrl import ro_meas_pkg::*; #(
    parameter int WIN_W         = WIN_W_DEF,
    parameter int CNT_W         = CNT_W_DEF,
    parameter int WARMUP_CYCLES = 8,
    parameter int SYNC_STAGES   = 2
) (
    input logic clk,
    input logic rst,
    ro_meas_ctrl_if.slave bus
);
    localparam int WU_W = $clog2(WARMUP_CYCLES + 1);
    localparam logic [WU_W-1:0] WU_LOAD = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(max_cnt(CNT_W));
    state_e state_q, state_d;
    logic [WIN_W-1:0] win_q, win_d, wc_q, wc_d;
    logic [WU_W-1:0] wu_q, wu_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic ovf_q, ovf_d;
    logic pulse;
    ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
        .clk(clk), .rst(rst), .d_i(bus.ro_clk), .pulse_o(pulse)
    );
    always_comb begin
        state_d = state_q;
        win_d = win_q;
        wc_d = wc_q;
        wu_d = wu_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        case (state_q)
            IDLE: if (bus.start) begin
                win_d = bus.win_len;
                wu_d = WU_LOAD;
                state_d = WARMUP;
            end
            WARMUP: begin
                wu_d = wu_q - 1'b1;
                if (wu_q == '0) begin
                    cnt_d = '0;
                    ovf_d = 1'b0;
                    wc_d = win_q - 1'b1;
                    state_d = (win_q == '0) ? DONE : MEASURE;
                end
            end
            MEASURE: begin
                wc_d = wc_q - 1'b1;
                cnt_d = (pulse && cnt_q != CNT_MAX) ? cnt_q + 1'b1 : cnt_q;
                ovf_d = ovf_q | (pulse && cnt_q == CNT_MAX);
                if (wc_q == '0) state_d = DONE;
            end
            DONE: if (bus.cnt_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            win_q <= '0;
            wc_q <= '0;
            wu_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q <= win_d;
            wc_q <= wc_d;
            wu_q <= wu_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end
    // outputs decode straight from state so reset drops ro_en without waiting for a clock
    assign bus.ro_en = (state_q == WARMUP) || (state_q == MEASURE);
    assign bus.busy = state_q != IDLE;
    assign bus.cnt_valid = state_q == DONE;
    assign bus.cnt_data = cnt_q;
    assign bus.cnt_ovf = ovf_q;
`ifdef RO_MEAS_ALARM_EN
    logic alarm_q;
    logic done_entry;
    assign done_entry = (state_q != DONE) && (state_d == DONE);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) alarm_q <= 1'b0;
        else if (done_entry && (cnt_d < bus.lim_lo || cnt_d > bus.lim_hi || ovf_d || cnt_d == CNT_MAX)) alarm_q <= 1'b1;
    end
    assign bus.alarm = alarm_q;
`endif
endmodule

// File: tb/tb_ro_meas_ctrl.sv
// tb_ro_meas_ctrl: table-driven and randomized checks of ro_meas_ctrl against an edges-per-window rate model
`timescale 1ns/1ps
module tb_ro_meas_ctrl;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ro = 1'b0;
    int half = 20;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    initial begin
        #0.3;
        forever #(half) ro = ~ro;
    end
    ro_meas_ctrl_if #(.WIN_W(16), .CNT_W(16)) bus();
    ro_meas_ctrl_if #(.WIN_W(16), .CNT_W(4)) bus4();
    assign bus.ro_clk = ro;
    assign bus4.ro_clk = ro;
    ro_meas_ctrl #(.WIN_W(16), .CNT_W(16), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );
    ro_meas_ctrl #(.WIN_W(16), .CNT_W(4), .WARMUP_CYCLES(W), .SYNC_STAGES(2)) dut4 (
        .clk(clk), .rst(rst), .bus(bus4)
    );
    typedef struct {int win; int half; int stall; int exp;} vec_t;
    vec_t tv[6];

    task automatic chk(input string n, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", n, got, exp);
        end
    endtask

    task automatic chk_tol(input string n, input int got, input int exp);
        checks++;
        if (got < exp - 1 || got > exp + 1) begin
            errors++;
            $display("FAIL %s got %0d expected %0d +-1", n, got, exp);
        end
    endtask

    // rate model: a window of win clocks (10 ns each) holds win*10/period edges, +-1
    task automatic near(input string n, input int got, input int win, input int per);
        int l;
        l = win * 10;
        checks++;
        if (got * per < l - per || got * per > l + per) begin
            errors++;
            $display("FAIL %s got %0d expected %0d/%0d +-1", n, got, l, per);
        end
    endtask

    task automatic settle(input int h);
        half = h;
        repeat (12) @(posedge clk);
        #1;
    endtask

    task automatic meas(input int win, input int stall, input bit hs_start,
                        output int got, output int ovf, output int cyc, output int en);
        bit stable;
        bus.cnt_ready = 1'b0;
        @(posedge clk); #1;
        bus.win_len = 16'(win);
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.win_len = 16'($urandom);
        cyc = 0;
        en = 0;
        while (!bus.cnt_valid && cyc < 5000) begin
            en += int'(bus.ro_en);
            @(posedge clk); #1;
            cyc++;
        end
        if (!bus.cnt_valid) begin
            checks++;
            errors++;
            $display("FAIL timeout waiting for cnt_valid win %0d", win);
        end
        got = int'(bus.cnt_data);
        ovf = int'(bus.cnt_ovf);
        stable = 1'b1;
        for (int k = 0; k < stall; k++) begin
            if (!bus.cnt_valid || int'(bus.cnt_data) != got || int'(bus.cnt_ovf) != ovf || !bus.busy || bus.ro_en)
                stable = 1'b0;
            bus.start = (k == stall / 2);
            @(posedge clk); #1;
        end
        bus.start = 1'b0;
        if (stall > 0) chk("stall_stable", int'(stable), 1);
        bus.cnt_ready = 1'b1;
        bus.start = hs_start;
        @(posedge clk); #1;
        bus.cnt_ready = 1'b0;
        bus.start = 1'b0;
        chk("valid_after_hs", int'(bus.cnt_valid), 0);
        chk("busy_after_hs", int'(bus.busy), 0);
    endtask

    initial begin
        int got, ovf, cyc, en, win, h, st;
        tv[0] = '{100, 20, 0, 25};
        tv[1] = '{100, 20, 20, 25};
        tv[2] = '{0, 20, 3, 0};
        tv[3] = '{1, 20, 0, 0};
        tv[4] = '{250, 11, 5, 114};
        tv[5] = '{37, 33, 0, 6};
        bus.start = 1'b0; bus.win_len = '0; bus.cnt_ready = 1'b0;
        bus4.start = 1'b0; bus4.win_len = '0; bus4.cnt_ready = 1'b0;
`ifdef RO_MEAS_ALARM_EN
        bus.lim_lo = '0; bus.lim_hi = '1;
        bus4.lim_lo = '0; bus4.lim_hi = '1;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ro_en", int'(bus.ro_en), 0);
        chk("rst_busy", int'(bus.busy), 0);
        chk("rst_valid", int'(bus.cnt_valid), 0);
        chk("rst_data", int'(bus.cnt_data), 0);
        chk("rst_ovf", int'(bus.cnt_ovf), 0);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            settle(tv[i].half);
            meas(tv[i].win, tv[i].stall, i == 1, got, ovf, cyc, en);
            chk($sformatf("tv%0d_cycles", i), cyc, W + tv[i].win);
            chk($sformatf("tv%0d_ro_en_cycles", i), en, W + tv[i].win);
            chk($sformatf("tv%0d_ovf", i), ovf, 0);
            if (tv[i].win == 0) chk("zero_win_data", got, 0);
            else chk_tol($sformatf("tv%0d_data", i), got, tv[i].exp);
        end
        for (int i = 0; i < 10; i++) begin
            win = $urandom_range(0, 300);
            h = $urandom_range(11, 50);
            st = $urandom_range(0, 4);
            settle(h);
            meas(win, st, 1'b0, got, ovf, cyc, en);
            chk($sformatf("rnd%0d_cycles", i), cyc, W + win);
            chk($sformatf("rnd%0d_ovf", i), ovf, 0);
            near($sformatf("rnd%0d_data", i), got, win, 2 * h);
        end
        settle(15);
        bus4.win_len = 16'd200;
        bus4.start = 1'b1;
        @(posedge clk); #1;
        bus4.start = 1'b0;
        cyc = 0;
        while (!bus4.cnt_valid && cyc < 5000) begin
            @(posedge clk); #1;
            cyc++;
        end
        chk("sat_cycles", cyc, W + 200);
        chk("sat_data", int'(bus4.cnt_data), 15);
        chk("sat_ovf", int'(bus4.cnt_ovf), 1);
        bus4.cnt_ready = 1'b1;
        @(posedge clk); #1;
        bus4.cnt_ready = 1'b0;
        chk("sat_hs_valid", int'(bus4.cnt_valid), 0);
        settle(20);
        bus.win_len = 16'd100;
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (W + 50) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("midrst_ro_en", int'(bus.ro_en), 0);
        chk("midrst_busy", int'(bus.busy), 0);
        chk("midrst_valid", int'(bus.cnt_valid), 0);
        chk("midrst_data", int'(bus.cnt_data), 0);
        chk("midrst_ovf", int'(bus.cnt_ovf), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        meas(100, 0, 1'b0, got, ovf, cyc, en);
        chk("postrst_cycles", cyc, W + 100);
        near("postrst_data", got, 100, 40);
`ifdef RO_MEAS_ALARM_EN
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("alarm_rst", int'(bus.alarm), 0);
        bus.lim_lo = 16'd30;
        bus.lim_hi = 16'd40;
        meas(100, 0, 1'b0, got, ovf, cyc, en);
        chk("alarm_low", int'(bus.alarm), 1);
        bus.lim_lo = 16'd0;
        bus.lim_hi = 16'd1000;
        meas(100, 0, 1'b0, got, ovf, cyc, en);
        chk("alarm_sticky", int'(bus.alarm), 1);
        rst = 1'b1;
        #1;
        chk("alarm_clear", int'(bus.alarm), 0);
        @(posedge clk); #1;
        rst = 1'b0;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
